// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction layout, FSM encoding.
package alu_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOT   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_ROL   = 4'd8,
    OP_ROR   = 4'd9,
    OP_PASSA = 4'd10,
    OP_PASSB = 4'd11,
    OP_NEG   = 4'd12,
    OP_NAND  = 4'd13,
    OP_INC   = 4'd14,
    OP_DEC   = 4'd15
  } alu_op_e;

  localparam int INSTR_W = 24;
  localparam int OP_W    = 4;
  localparam int REG_AW  = 3;
  localparam int IMM_W   = 9;
  localparam int CNT_W   = 4;

  // Field order matches instr[23:0]: op, rd, ra, rb, imm_sel, reserved, imm9.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic              imm_sel;
    logic              rsvd;
    logic [IMM_W-1:0]  imm9;
  } instr_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/alu_issue_rf.sv
// NREG x DW register file: one write port, two operand read ports, one debug read port; r0 is hard zero.
module alu_issue_rf
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DW   = 9,
  parameter int NREG = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DW-1:0]     ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DW-1:0]     rb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DW-1:0]     dbg_data
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign ra_data  = (ra_addr  == '0) ? '0 : mem[ra_addr];
  assign rb_data  = (rb_addr  == '0) ? '0 : mem[rb_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational 9-bit ALU: accepts an instruction, drives the ALU,
// waits ALU_LAT cycles, then writes the sampled result back and pulses res_valid.
//   state  | meaning
//   S_IDLE | ready for an instruction; operands are captured on the accept edge
//   S_EXEC | ALU inputs held; cnt counts down, retire when cnt reaches 0
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DW      = 9,
  parameter int NREG    = 8,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [23:0]   instr,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_s,
  input  logic [DW-1:0] alu_out,
  output logic          res_valid,
  output logic [2:0]    res_rd,
  output logic [DW-1:0] res_data,
  output logic          res_zero,
  output logic          busy,
  input  logic [2:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_e            state, state_nxt;
  instr_t            f;
  logic [CNT_W-1:0]  cnt;
  logic [REG_AW-1:0] rd_q;
  logic [DW-1:0]     ra_data, rb_data;
  logic              accept, retire;
  logic              unused_rsvd;

  assign f           = instr;
  assign unused_rsvd = f.rsvd;

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    accept      = 1'b0;
    retire      = 1'b0;
    unique case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        accept      = instr_valid;
        if (instr_valid) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (cnt == '0) begin
          retire    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = ~instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ALU lanes only move on accept so the ALU sees stable inputs for the whole settle window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_s <= '0;
      rd_q  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      alu_a <= ra_data;
      alu_b <= f.imm_sel ? DW'(f.imm9) : rb_data;
      alu_s <= f.op;
      rd_q  <= f.rd;
      cnt   <= CNT_W'(ALU_LAT - 1);
    end else if ((state == S_EXEC) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_rd    <= '0;
      res_data  <= '0;
      res_zero  <= 1'b0;
    end else begin
      res_valid <= retire;
      if (retire) begin
        res_rd   <= rd_q;
        res_data <= alu_out;
        res_zero <= (alu_out == '0);
      end
    end
  end

  alu_issue_rf #(
    .DW   (DW),
    .NREG (NREG)
  ) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (retire),
    .waddr    (rd_q),
    .wdata    (alu_out),
    .ra_addr  (f.ra),
    .ra_data  (ra_data),
    .rb_addr  (f.rb),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU and register-file model.
module tb_alu_issue_ctrl;

  localparam int DW  = 9;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [23:0]   instr = '0;
  logic [DW-1:0] alu_a, alu_b, alu_out, res_data, dbg_data;
  logic [3:0]    alu_s;
  logic          res_valid, res_zero, busy;
  logic [2:0]    res_rd;
  logic [2:0]    dbg_addr = '0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_ctrl #(.DW(DW), .NREG(8), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
    .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data), .res_zero(res_zero),
    .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [8:0] a, input logic [8:0] b);
    case (op)
      4'd0:    return 9'(a + b);
      4'd1:    return 9'(a - b);
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~a;
      4'd6:    return {a[7:0], 1'b0};
      4'd7:    return {1'b0, a[8:1]};
      4'd8:    return {a[7:0], a[8]};
      4'd9:    return {a[0], a[8:1]};
      4'd10:   return a;
      4'd11:   return b;
      4'd12:   return 9'(-a);
      4'd13:   return ~(a & b);
      4'd14:   return 9'(a + 9'd1);
      default: return 9'(a - 9'd1);
    endcase
  endfunction

  assign alu_out = alu_fn(alu_s, alu_a, alu_b);

  typedef struct {
    logic [2:0] rd;
    logic [8:0] data;
    logic [8:0] old;
    int         due;
  } exp_t;

  typedef struct {
    logic [8:0] a;
    logic [8:0] b;
    logic [3:0] s;
    int         at;
  } opx_t;

  exp_t       expq[$];
  opx_t       opq[$];
  logic [8:0] mrf[8];
  int         n_cmp = 0;
  int         n_err = 0;
  int         last_acc = -100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: expected busy window comes from the model's accept times, results from the queue.
  always @(negedge clk) begin
    int   d;
    logic bexp;
    exp_t e;
    if (rst_n) begin
      d    = cyc - last_acc;
      bexp = (d >= 0) && (d < LAT);
      chk("busy", 32'(busy), 32'(bexp));
      chk("instr_ready", 32'(instr_ready), 32'(!bexp));
      if (opq.size() > 0 && opq[0].at == cyc) begin
        chk("alu_a", 32'(alu_a), 32'(opq[0].a));
        chk("alu_b", 32'(alu_b), 32'(opq[0].b));
        chk("alu_s", 32'(alu_s), 32'(opq[0].s));
        void'(opq.pop_front());
      end
      if (expq.size() > 0 && cyc == expq[0].due - 1 && dbg_addr == expq[0].rd)
        chk("dbg_before_wb", 32'(dbg_data), 32'(expq[0].old));
      if (res_valid) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_res_valid: actual res_rd=%0d res_data=%0h required no pulse (cyc %0d)",
                   res_rd, res_data, cyc);
        end else begin
          e = expq.pop_front();
          chk("res_cycle", 32'(cyc), 32'(e.due));
          chk("res_rd", 32'(res_rd), 32'(e.rd));
          chk("res_data", 32'(res_data), 32'(e.data));
          chk("res_zero", 32'(res_zero), 32'(e.data == 9'd0));
          if (dbg_addr == e.rd) chk("dbg_after_wb", 32'(dbg_data), 32'((e.rd == 3'd0) ? 9'd0 : e.data));
        end
      end else if (expq.size() > 0 && cyc >= expq[0].due) begin
        n_cmp++;
        n_err++;
        $display("FAIL missing_res_valid: actual none required rd=%0d data=%0h (cyc %0d)",
                 expq[0].rd, expq[0].data, cyc);
        void'(expq.pop_front());
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic isel, input logic [8:0] imm, output int acc);
    logic [8:0] a, b, r;
    bit done;
    done = 0;
    acc  = -1;
    @(negedge clk);
    instr       = {op, rd, ra, rb, isel, 1'($urandom), imm};
    instr_valid = 1'b1;
    dbg_addr    = rd;
    for (int i = 0; i < 40 && !done; i++) begin
      if (i > 0) @(negedge clk);
      if (instr_ready) begin
        a   = (ra == 3'd0) ? 9'd0 : mrf[ra];
        b   = isel ? imm : ((rb == 3'd0) ? 9'd0 : mrf[rb]);
        r   = alu_fn(op, a, b);
        acc = cyc + 1;
        last_acc = acc;
        opq.push_back('{a: a, b: b, s: op, at: acc});
        expq.push_back('{rd: rd, data: r, old: (rd == 3'd0) ? 9'd0 : mrf[rd], due: acc + LAT});
        if (rd != 3'd0) mrf[rd] = r;
        done = 1;
        @(posedge clk);
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: actual no accept required accept within 40 cycles (cyc %0d)", cyc);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 24'($urandom);
    repeat (n) @(posedge clk);
  endtask

  task automatic dbg_sweep();
    for (int i = 0; i < 40 && expq.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk($sformatf("dbg_r%0d", i), 32'(dbg_data), 32'((i == 0) ? 9'd0 : mrf[i]));
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    expq.delete();
    opq.delete();
    for (int i = 0; i < 8; i++) mrf[i] = 9'd0;
    last_acc = -100;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual still running required finish (cyc %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, a1, a2, a3;
    for (int i = 0; i < 8; i++) mrf[i] = 9'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_s", 32'(alu_s), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_rd", 32'(res_rd), 32'd0);
    chk("rst_res_zero", 32'(res_zero), 32'd0);
    chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    #1 rst_n = 1'b1;

    // Immediate load
    issue(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 9'h0FF, a0);
    idle(2);
    dbg_sweep();

    // Dependent pair with valid held high: second accept lands in the first result's cycle
    issue(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 9'd3, a1);
    issue(4'd14, 3'd2, 3'd1, 3'd5, 1'b0, 9'd0, a2);
    chk("b2b_spacing", 32'(a2 - a1), 32'(LAT + 1));
    idle(LAT + 2);
    dbg_sweep();

    // Wraparound to zero
    issue(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 9'h1FF, a0);
    issue(4'd0, 3'd3, 3'd1, 3'd0, 1'b1, 9'd1, a1);
    idle(LAT + 2);
    dbg_sweep();

    // r0 write is discarded but still reported
    issue(4'd1, 3'd0, 3'd0, 3'd0, 1'b1, 9'd1, a0);
    idle(LAT + 2);
    dbg_sweep();

    // Stall: three instructions offered continuously
    issue(4'd4, 3'd4, 3'd1, 3'd3, 1'b0, 9'd0, a1);
    issue(4'd8, 3'd5, 3'd4, 3'd0, 1'b1, 9'h155, a2);
    issue(4'd1, 3'd6, 3'd5, 3'd4, 1'b0, 9'd0, a3);
    chk("stall_spacing_1", 32'(a2 - a1), 32'(LAT + 1));
    chk("stall_spacing_2", 32'(a3 - a2), 32'(LAT + 1));
    idle(LAT + 2);
    dbg_sweep();

    // Reset half a cycle after accept aborts the instruction
    issue(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 9'd5, a0);
    @(negedge clk);
    #1;
    do_reset();
    @(negedge clk);
    dbg_addr = 3'd1;
    #1;
    chk("abort_dbg_r1", 32'(dbg_data), 32'd0);
    chk("abort_ready", 32'(instr_ready), 32'd1);
    idle(LAT + 3);
    dbg_sweep();

    // Randomised traffic
    for (int n = 0; n < 200; n++) begin
      issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 9'($urandom), a0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
    end
    idle(LAT + 3);
    dbg_sweep();
    chk("results_drained", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
